character_motion_ctrl: RTL and testbench



---
 rtl/character_motion_ctrl.sv | 120 ++++++++++++
 tb/tb_character_motion_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/character_motion_ctrl.sv
// Per-frame motion sequencer for one character: clamped horizontal stepping plus
// a ground/rise/fall jump machine with integer gravity, advanced only on accepted frame ticks.
module character_motion_ctrl #(
  parameter int WIDTH    = 64,
  parameter int HEIGHT   = 64,
  parameter int X_INIT   = 0,
  parameter int FLOOR_Y  = 704,
  parameter int STEP_X   = 4,
  parameter int JUMP_V0  = 16,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       on_ground,
  output logic [1:0] state,
  output logic       upd
);

  localparam int X_MAX = 1024 - WIDTH;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } state_t;

  state_t     st, st_nx;
  logic [5:0] vel, vel_nx;
  logic [9:0] x_nx, y_nx;
  logic       accept;
  int         x_l, x_r, y_up, y_dn, v_up;

  assign accept = frame_tick & ~freeze;
  assign state  = st;

  // Wide signed intermediates keep the clamps free of wrap-around.
  always_comb begin
    x_l    = int'(xpos) - STEP_X;
    x_r    = int'(xpos) + STEP_X;
    y_up   = int'(ypos) - int'(vel);
    y_dn   = int'(ypos) + int'(vel);
    v_up   = int'(vel) + GRAVITY;
    x_nx   = xpos;
    y_nx   = ypos;
    vel_nx = vel;
    st_nx  = st;

    if (move_left && !move_right)
      x_nx = (x_l <= 0) ? '0 : 10'(x_l);
    else if (move_right && !move_left)
      x_nx = (x_r >= X_MAX) ? 10'(X_MAX) : 10'(x_r);

    case (st)
      GROUND: begin
        if (jump) begin
          vel_nx = 6'(JUMP_V0);
          st_nx  = RISING;
        end
      end
      RISING: begin
        if (y_up <= 0) begin
          y_nx   = '0;
          vel_nx = '0;
          st_nx  = FALLING;
        end else begin
          y_nx = 10'(y_up);
          if (int'(vel) <= GRAVITY) begin
            vel_nx = '0;
            st_nx  = FALLING;
          end else begin
            vel_nx = 6'(int'(vel) - GRAVITY);
          end
        end
      end
      FALLING: begin
        if (y_dn >= FLOOR_Y) begin
          y_nx   = 10'(FLOOR_Y);
          vel_nx = '0;
          st_nx  = GROUND;
        end else begin
          y_nx   = 10'(y_dn);
          vel_nx = (v_up >= MAX_FALL) ? 6'(MAX_FALL) : 6'(v_up);
        end
      end
      default: begin
        vel_nx = '0;
        st_nx  = FALLING;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos      <= 10'(X_INIT);
      ypos      <= 10'(FLOOR_Y);
      vel       <= '0;
      st        <= GROUND;
      on_ground <= 1'b1;
      upd       <= 1'b0;
    end else begin
      upd <= accept;
      if (accept) begin
        xpos      <= x_nx;
        ypos      <= y_nx;
        vel       <= vel_nx;
        st        <= st_nx;
        on_ground <= (st_nx == GROUND);
      end
    end
  end

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Self-checking bench for character_motion_ctrl: fixed vector table, hand-built
// jump/freeze/reset sequences, then random stimulus against a frame-level model.
module tb_character_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, freeze = 1'b0;
  logic       move_left = 1'b0, move_right = 1'b0, jump = 1'b0;
  logic [9:0] xpos, ypos;
  logic       on_ground, upd;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the character in plain integers: position, speed and phase.
  int mx, my, mv, ms, mu;

  character_motion_ctrl #(
    .WIDTH(64), .HEIGHT(64), .X_INIT(0), .FLOOR_Y(704),
    .STEP_X(4), .JUMP_V0(16), .GRAVITY(1), .MAX_FALL(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .freeze(freeze),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .xpos(xpos), .ypos(ypos), .on_ground(on_ground), .state(state), .upd(upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit t, f, l, r, j;
    int x, y, s, u;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 704; mv = 0; ms = 0; mu = 0;
  endtask

  task automatic model_frame(input bit l, input bit r, input bit j);
    if (l && !r) mx = (mx - 4 < 0) ? 0 : mx - 4;
    else if (r && !l) mx = (mx + 4 > 960) ? 960 : mx + 4;
    if (ms == 0) begin
      if (j) begin mv = 16; ms = 1; end
    end else if (ms == 1) begin
      if (my - mv <= 0) begin my = 0; mv = 0; ms = 2; end
      else begin
        my = my - mv;
        if (mv <= 1) begin mv = 0; ms = 2; end
        else mv = mv - 1;
      end
    end else begin
      if (my + mv >= 704) begin my = 704; mv = 0; ms = 0; end
      else begin my = my + mv; mv = (mv + 1 > 16) ? 16 : mv + 1; end
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 ns after the posedge.
  task automatic step(input bit t, input bit f, input bit l, input bit r, input bit j);
    @(negedge clk);
    frame_tick = t; freeze = f; move_left = l; move_right = r; jump = j;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    mu = (t && !f) ? 1 : 0;
    if (t && !f) model_frame(l, r, j);
  endtask

  task automatic cmp_model(input string nm);
    chk({nm, ".x"}, int'(xpos), mx);
    chk({nm, ".y"}, int'(ypos), my);
    chk({nm, ".state"}, int'(state), ms);
    chk({nm, ".on_ground"}, int'(on_ground), (ms == 0) ? 1 : 0);
    chk({nm, ".upd"}, int'(upd), mu);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_tick = 1'b0; freeze = 1'b0; move_left = 1'b0; move_right = 1'b0; jump = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0,   0, 704, 0, 1};
    tbl[1]  = '{0, 0, 0, 1, 0,   0, 704, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 0,   4, 704, 0, 1};
    tbl[3]  = '{1, 0, 0, 1, 0,   8, 704, 0, 1};
    tbl[4]  = '{1, 0, 1, 0, 0,   4, 704, 0, 1};
    tbl[5]  = '{1, 0, 1, 1, 0,   4, 704, 0, 1};
    tbl[6]  = '{1, 0, 1, 0, 0,   0, 704, 0, 1};
    tbl[7]  = '{1, 0, 1, 0, 0,   0, 704, 0, 1};
    tbl[8]  = '{1, 1, 0, 1, 1,   0, 704, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 1,   0, 704, 1, 1};
    tbl[10] = '{1, 0, 1, 0, 1,   0, 688, 1, 1};
    tbl[11] = '{1, 1, 0, 1, 0,   0, 688, 1, 0};
    tbl[12] = '{1, 0, 0, 1, 0,   4, 673, 1, 1};

    do_reset();
    @(posedge clk); #1;
    chk("reset.x", int'(xpos), 0);
    chk("reset.y", int'(ypos), 704);
    chk("reset.state", int'(state), 0);
    chk("reset.on_ground", int'(on_ground), 1);
    chk("reset.upd", int'(upd), 0);

    // Idle ticks: upd pulses once per tick and drops on the following cycle.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0);
      cmp_model("idle_tick");
      chk("idle_tick.upd", int'(upd), 1);
      step(0, 0, 0, 0, 0);
      chk("idle_gap.upd", int'(upd), 0);
    end

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].t, tbl[i].f, tbl[i].l, tbl[i].r, tbl[i].j);
      chk($sformatf("vec%0d.x", i), int'(xpos), tbl[i].x);
      chk($sformatf("vec%0d.y", i), int'(ypos), tbl[i].y);
      chk($sformatf("vec%0d.state", i), int'(state), tbl[i].s);
      chk($sformatf("vec%0d.upd", i), int'(upd), tbl[i].u);
    end

    // Right wall saturation, then both directions held.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0, 1, 0);
      if (i < 5 || i > 235) cmp_model("right_run");
    end
    chk("right_sat.x", int'(xpos), 960);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0);
    chk("both_hold.x", int'(xpos), 960);

    // Jump held: tick 0 leaves the ground, peak at tick 16, land 33, relaunch 34.
    do_reset();
    for (int i = 0; i <= 35; i++) begin
      step(1, 0, 0, 0, 1);
      cmp_model("jump_held");
      if (i == 16) begin chk("peak.y", int'(ypos), 568); chk("peak.state", int'(state), 2); end
      if (i == 18) chk("fall2.y", int'(ypos), 569);
      if (i == 19) chk("fall3.y", int'(ypos), 571);
      if (i == 33) begin chk("land.y", int'(ypos), 704); chk("land.state", int'(state), 0); end
      if (i == 34) begin chk("relaunch.y", int'(ypos), 704); chk("relaunch.state", int'(state), 1); end
      if (i == 35) chk("relaunch2.y", int'(ypos), 688);
    end

    // Freeze mid-rise, then resume from the same point.
    do_reset();
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    chk("pre_freeze.y", int'(ypos), 659);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 1, 1);
      chk("frozen.y", int'(ypos), 659);
      chk("frozen.state", int'(state), 1);
      chk("frozen.upd", int'(upd), 0);
    end
    step(1, 0, 0, 0, 0);
    chk("resume.y", int'(ypos), 646);
    cmp_model("resume");

    // Asynchronous reset while falling, asserted between clock edges.
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0);
    chk("mid_fall.state", int'(state), 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.x", int'(xpos), 0);
    chk("async_rst.y", int'(ypos), 704);
    chk("async_rst.state", int'(state), 0);
    chk("async_rst.on_ground", int'(on_ground), 1);
    chk("async_rst.upd", int'(upd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Random play against the model, checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 3) == 0));
      cmp_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
